// File: rtl/ioctl_download_streamer.sv
// ioctl download streamer: fetches bytes from a request/acknowledge source
// and replays them as an ioctl write stream into a core.
//
// state  | meaning
// IDLE   | waiting for start
// SETUP  | ioctl_download raised, settling before the first fetch
// FETCH  | src_req high, waiting for src_ack
// WRITE  | single-cycle ioctl_wr strobe
// GAP    | idle spacing after a write
// HOLD   | core is back-pressuring via ioctl_wait
// FINISH | done pulse, download window closed
module ioctl_download_streamer #(
  parameter int ADDR_W = 25,
  parameter int SETUP  = 2,
  parameter int GAP    = 3
) (
  input  logic              clk_48,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [7:0]        index,
  input  logic              abort,
  output logic              src_req,
  output logic [ADDR_W-1:0] src_addr,
  input  logic              src_ack,
  input  logic [7:0]        src_data,
  output logic              ioctl_download,
  output logic              ioctl_wr,
  output logic [ADDR_W-1:0] ioctl_addr,
  output logic [7:0]        ioctl_dout,
  output logic [7:0]        ioctl_index,
  input  logic              ioctl_wait,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_FETCH, S_WRITE, S_GAP, S_HOLD, S_FINISH
  } state_t;

  localparam logic [3:0] SETUP_LD = 4'(SETUP - 1);
  localparam logic [3:0] GAP_LD   = 4'((GAP == 0) ? 0 : GAP - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [3:0]        tmr_q, tmr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        dout_q, dout_d;
  logic [7:0]        index_q, index_d;
  logic              zdone_q, zdone_d;

  logic [ADDR_W-1:0] cnt_inc;
  logic [ADDR_W-1:0] cnt_chk;
  state_t            exit_state;

  // Decision taken when the post-write gap ends; in WRITE (zero gap) the
  // count has not been incremented yet, so look at the incremented value.
  always_comb begin
    cnt_inc = cnt_q + ADDR_W'(1);
    cnt_chk = (state_q == S_WRITE) ? cnt_inc : cnt_q;
    if (cnt_chk == len_q)
      exit_state = S_FINISH;
    else if (ioctl_wait)
      exit_state = S_HOLD;
    else
      exit_state = S_FETCH;
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    len_d   = len_q;
    tmr_d   = tmr_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    index_d = index_q;
    zdone_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length != '0) begin
            base_d  = base_addr;
            len_d   = length;
            index_d = index;
            cnt_d   = '0;
            tmr_d   = SETUP_LD;
            state_d = S_SETUP;
          end else begin
            zdone_d = 1'b1;
          end
        end
      end
      S_SETUP: begin
        if (tmr_q == 4'd0) state_d = S_FETCH;
        else               tmr_d   = tmr_q - 4'd1;
      end
      S_FETCH: begin
        if (src_ack) begin
          dout_d  = src_data;
          addr_d  = base_q + cnt_q;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        cnt_d = cnt_inc;
        if (GAP == 0) begin
          state_d = exit_state;
        end else begin
          tmr_d   = GAP_LD;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (tmr_q == 4'd0) state_d = exit_state;
        else               tmr_d   = tmr_q - 4'd1;
      end
      S_HOLD: begin
        if (!ioctl_wait) state_d = S_FETCH;
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Abort drops everything in flight, including a byte acked this cycle.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      addr_d  = addr_q;
      dout_d  = dout_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_48 or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      len_q   <= '0;
      tmr_q   <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      index_q <= '0;
      zdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      len_q   <= len_d;
      tmr_q   <= tmr_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      index_q <= index_d;
      zdone_q <= zdone_d;
    end
  end

  // Outputs decode directly from state so reset and abort take effect at once.
  always_comb begin
    src_req        = (state_q == S_FETCH);
    src_addr       = cnt_q;
    ioctl_download = (state_q == S_SETUP) || (state_q == S_FETCH) ||
                     (state_q == S_WRITE) || (state_q == S_GAP)   ||
                     (state_q == S_HOLD);
    ioctl_wr       = (state_q == S_WRITE);
    ioctl_addr     = addr_q;
    ioctl_dout     = dout_q;
    ioctl_index    = index_q;
    busy           = (state_q != S_IDLE);
    done           = (state_q == S_FINISH) || zdone_q;
  end

endmodule

// File: tb/tb_ioctl_download_streamer.sv
// Scoreboard bench for ioctl_download_streamer: expected writes are queued
// when a transfer is launched and popped by a monitor on every ioctl_wr.
module tb_ioctl_download_streamer;
  localparam int AW    = 25;
  localparam int SETUP = 2;
  localparam int GAP   = 3;

  logic          clk_48 = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] length = '0;
  logic [7:0]    index = '0;
  logic          abort = 1'b0;
  logic          src_req;
  logic [AW-1:0] src_addr;
  logic          src_ack;
  logic [7:0]    src_data = '0;
  logic          ioctl_download, ioctl_wr;
  logic [AW-1:0] ioctl_addr;
  logic [7:0]    ioctl_dout, ioctl_index;
  logic          ioctl_wait;
  logic          busy, done;

  always #5 clk_48 = ~clk_48;

  ioctl_download_streamer #(.ADDR_W(AW), .SETUP(SETUP), .GAP(GAP)) dut (
    .clk_48(clk_48), .reset(reset), .start(start), .base_addr(base_addr),
    .length(length), .index(index), .abort(abort), .src_req(src_req),
    .src_addr(src_addr), .src_ack(src_ack), .src_data(src_data),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait), .busy(busy),
    .done(done)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk_48) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- byte source model ----------------
  logic [7:0] salt = 8'hA0;
  logic [7:0] mult = 8'h01;
  int         max_dly = 0;
  int         force_dly = -1;
  int         src_dly = 0;
  logic       src_ack_s = 1'b0;
  logic       late_ack = 1'b0;
  assign src_ack = src_ack_s | late_ack;

  function automatic logic [7:0] src_byte(logic [AW-1:0] off);
    logic [7:0] o;
    o = off[7:0];
    return salt + o * mult;
  endfunction

  always @(negedge clk_48) begin
    if (src_req && !reset) begin
      if (src_dly == 0) begin
        src_ack_s = 1'b1;
        src_data  = src_byte(src_addr);
      end else begin
        src_ack_s = 1'b0;
        src_dly   = src_dly - 1;
      end
    end else begin
      src_ack_s = 1'b0;
      src_dly   = (force_dly >= 0) ? force_dly : $urandom_range(0, max_dly);
    end
  end

  // ---------------- back-pressure ----------------
  logic wait_dir = 1'b0;
  logic wait_rnd = 1'b0;
  logic wait_rand_en = 1'b0;
  assign ioctl_wait = wait_dir | wait_rnd;

  always @(posedge clk_48) begin
    #1;
    wait_rnd = wait_rand_en && ($urandom_range(0, 3) == 0);
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic [7:0]    idx;
  } wr_t;
  wr_t exp_q[$];
  int  wr_times[$];
  int  done_cnt = 0;
  int  last_done = -1;

  always @(negedge clk_48) begin
    wr_t e;
    if (ioctl_wr) begin
      wr_times.push_back(cyc);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", ioctl_addr, ioctl_dout);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(ioctl_addr), 32'(e.addr));
        check("wr_data", 32'(ioctl_dout), 32'(e.data));
        check("wr_index", 32'(ioctl_index), 32'(e.idx));
        check("wr_in_window", 32'(ioctl_download), 32'd1);
      end
    end
    if (done) begin
      done_cnt++;
      last_done = cyc;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(int n);
    repeat (n) @(posedge clk_48);
    #1;
  endtask

  task automatic push_exp(logic [AW-1:0] base, logic [AW-1:0] len, logic [7:0] idx);
    wr_t e;
    for (int n = 0; n < int'(len); n++) begin
      e.addr = base + AW'(n);
      e.data = src_byte(AW'(n));
      e.idx  = idx;
      exp_q.push_back(e);
    end
  endtask

  task automatic do_start(logic [AW-1:0] base, logic [AW-1:0] len, logic [7:0] idx);
    base_addr = base;
    length    = len;
    index     = idx;
    start     = 1'b1;
    tick(1);
    start     = 1'b0;
    base_addr = $urandom;
    length    = $urandom;
    index     = $urandom;
  endtask

  task automatic wait_done(int budget, output int at);
    int k;
    k  = 0;
    at = -1;
    while (k < budget) begin
      @(negedge clk_48);
      if (done) begin
        at = cyc;
        break;
      end
      k++;
    end
    check("done_seen", 32'(at >= 0), 32'd1);
  endtask

  task automatic run_transfer(logic [AW-1:0] base, logic [AW-1:0] len,
                              logic [7:0] idx, bit mid_start);
    int d0, w0, at;
    d0 = done_cnt;
    w0 = wr_times.size();
    push_exp(base, len, idx);
    do_start(base, len, idx);
    check("busy_after_start", 32'(busy), 32'd1);
    check("download_after_start", 32'(ioctl_download), 32'd1);
    if (mid_start) begin
      tick(6);
      do_start(base + 25'h1000, len + 25'd4, idx ^ 8'hFF);
    end
    wait_done(int'(len) * 60 + 60, at);
    tick(3);
    check("writes_left", 32'(exp_q.size()), 32'd0);
    check("wr_count", 32'(wr_times.size() - w0), 32'(len));
    check("done_count", 32'(done_cnt - d0), 32'd1);
    check("download_idle", 32'(ioctl_download), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int w0, d0, wcyc, fc, k;
    tick(3);
    check("rst_download", 32'(ioctl_download), 32'd0);
    check("rst_wr", 32'(ioctl_wr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_src_req", 32'(src_req), 32'd0);
    check("rst_addr", 32'(ioctl_addr), 32'd0);
    check("rst_dout", 32'(ioctl_dout), 32'd0);
    check("rst_index", 32'(ioctl_index), 32'd0);
    reset = 1'b0;
    tick(2);

    // 1: basic 4-byte transfer, immediate ack
    salt = 8'hA0; mult = 8'h01; max_dly = 0;
    w0 = wr_times.size();
    run_transfer(25'h0, 25'd4, 8'h00, 1'b0);
    if (wr_times.size() - w0 == 4) begin
      for (int i = 1; i < 4; i++)
        check("wr_spacing", 32'(wr_times[w0+i] - wr_times[w0+i-1]), 32'd2 + GAP);
      check("done_after_last_wr", 32'(last_done - wr_times[w0+3]), 32'(GAP + 1));
    end

    // 2: back-pressure after the second write
    salt = 8'h11; mult = 8'h03;
    w0 = wr_times.size();
    d0 = done_cnt;
    push_exp(25'h100, 25'd6, 8'h22);
    do_start(25'h100, 25'd6, 8'h22);
    k = 0;
    while (wr_times.size() - w0 < 2 && k < 200) begin
      @(negedge clk_48); #1; k++;
    end
    check("second_write_seen", 32'(wr_times.size() - w0 >= 2), 32'd1);
    wcyc = cyc;
    tick(1);
    wait_dir = 1'b1;
    repeat (10) begin
      @(negedge clk_48);
      check("no_req_in_stall", 32'(src_req), 32'd0);
      tick(1);
    end
    wait_dir = 1'b0;
    fc = -1;
    k = 0;
    while (k < 50) begin
      @(negedge clk_48);
      if (src_req) begin fc = cyc; break; end
      k++;
    end
    check("fetch_resume", 32'(fc - wcyc), 32'd12);
    k = 0;
    while (wr_times.size() - w0 < 3 && k < 50) begin
      @(negedge clk_48); #1; k++;
    end
    if (wr_times.size() - w0 >= 3)
      check("wr3_after_fetch", 32'(wr_times[w0+2] - fc), 32'd1);
    else
      check("wr3_seen", 32'd0, 32'd1);
    wait_done(400, k);
    tick(3);
    check("t2_writes_left", 32'(exp_q.size()), 32'd0);
    check("t2_done_count", 32'(done_cnt - d0), 32'd1);

    // 3: zero-length start
    w0 = wr_times.size();
    d0 = done_cnt;
    do_start(25'h55, 25'd0, 8'h05);
    @(negedge clk_48);
    check("len0_done", 32'(done), 32'd1);
    check("len0_download", 32'(ioctl_download), 32'd0);
    check("len0_busy", 32'(busy), 32'd0);
    @(negedge clk_48);
    check("len0_done_pulse", 32'(done), 32'd0);
    tick(3);
    check("len0_no_wr", 32'(wr_times.size() - w0), 32'd0);
    check("len0_done_count", 32'(done_cnt - d0), 32'd1);

    // 4: address wrap
    salt = 8'h5A; mult = 8'h07; max_dly = 2;
    run_transfer(25'h1FFFFFE, 25'd4, 8'h44, 1'b0);

    // 5: abort during a slow fetch, late ack, then clean restart with ignored mid start
    max_dly = 0;
    force_dly = 40;
    w0 = wr_times.size();
    d0 = done_cnt;
    do_start(25'h40, 25'd3, 8'h66);
    tick(4);
    check("abort_in_fetch", 32'(src_req), 32'd1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort_download", 32'(ioctl_download), 32'd0);
    check("abort_src_req", 32'(src_req), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    late_ack = 1'b1;
    tick(1);
    late_ack = 1'b0;
    force_dly = -1;
    tick(8);
    check("abort_no_wr", 32'(wr_times.size() - w0), 32'd0);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_download_low", 32'(ioctl_download), 32'd0);
    salt = 8'h3C; mult = 8'h05;
    run_transfer(25'h800, 25'd5, 8'h77, 1'b1);
    tick(10);
    check("mid_start_no_extra", 32'(exp_q.size()), 32'd0);

    // 6: reset asserted during WRITE
    salt = 8'h90; mult = 8'h01;
    d0 = done_cnt;
    push_exp(25'h300, 25'd4, 8'h09);
    do_start(25'h300, 25'd4, 8'h09);
    k = 0;
    while (k < 100) begin
      @(negedge clk_48); #1;
      if (ioctl_wr) break;
      k++;
    end
    check("t6_write_seen", 32'(ioctl_wr), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_wr", 32'(ioctl_wr), 32'd0);
    check("rst_mid_download", 32'(ioctl_download), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_addr", 32'(ioctl_addr), 32'd0);
    check("rst_mid_dout", 32'(ioctl_dout), 32'd0);
    exp_q.delete();
    tick(2);
    reset = 1'b0;
    tick(3);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_download", 32'(ioctl_download), 32'd0);
    check("post_rst_no_done", 32'(done_cnt - d0), 32'd0);

    // 7: randomized transfers with random ack delay and back-pressure
    wait_rand_en = 1'b1;
    for (int t = 0; t < 8; t++) begin
      salt    = $urandom;
      mult    = $urandom;
      max_dly = $urandom_range(0, 3);
      run_transfer(AW'($urandom), AW'($urandom_range(1, 10)), 8'($urandom), 1'b0);
    end
    wait_rand_en = 1'b0;
    tick(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
